uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: frames a DATA_BITS payload with start, optional parity
// and STOP_BITS stop bits, advancing one bit per baud_tick strobe.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [1:0]           stop_cnt, stop_cnt_nxt;
    logic                 par_bit, par_nxt;
    logic                 tx_nxt;
    logic                 done_nxt;

    // Parity of the payload: even mode sends the XOR, odd mode its inverse.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            return ~(^d);
        end
        return ^d;
    endfunction

    // State and datapath registers; reset wins over accept and baud_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            par_bit  <= par_nxt;
            tx       <= tx_nxt;
        end
    end

    // Next-state logic; tx is loaded with the level of the state being entered
    // so the line changes on the cycle after the tick that ends an interval.
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        par_nxt      = par_bit;
        tx_nxt       = tx;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                // A tick arriving with the accept is not consumed here; SYNC
                // waits for the next one so the start bit is a full interval.
                tx_nxt = 1'b1;
                if (tx_valid) begin
                    state_nxt    = SYNC;
                    shreg_nxt    = tx_data;
                    par_nxt      = calc_parity(tx_data);
                    bit_cnt_nxt  = '0;
                    stop_cnt_nxt = '0;
                end
            end
            SYNC: begin
                if (baud_tick) begin
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_nxt = DATA;
                    tx_nxt    = shreg[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_nxt = '0;
                        if (PARITY != 0) begin
                            state_nxt = PAR;
                            tx_nxt    = par_bit;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        shreg_nxt   = {1'b0, shreg[DATA_BITS-1:1]};
                        tx_nxt      = shreg[1];
                    end
                end
            end
            PAR: begin
                if (baud_tick) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_nxt    = IDLE;
                        stop_cnt_nxt = '0;
                        done_nxt     = 1'b1;
                    end else begin
                        stop_cnt_nxt = stop_cnt + 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // Status outputs are forced inactive while reset is asserted.
    always_comb begin
        tx_ready   = (state == IDLE) & ~rst;
        busy       = (state != IDLE) & ~rst;
        frame_done = done_nxt & ~rst;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four instances cover no parity, even parity,
// odd parity and two stop bits; a monitor decodes each frame per tick interval.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       baud_tick;
    logic [3:0] tv;
    logic [7:0] td [4];
    wire  [3:0] tx_v, busy_v, done_v, ready_v;

    int tick_mode = 1;  // 0: none, 1: every 4 clk, 2: every clk
    int tick_cnt;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;

    typedef struct {
        int          dut;
        logic [15:0] bits;
        int          len;
    } exp_t;

    exp_t sb_q[$];

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(td[0]), .tx_valid(tv[0]),
        .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(td[1]), .tx_valid(tv[1]),
        .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(td[2]), .tx_valid(tv[2]),
        .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));
    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(td[3]), .tx_valid(tv[3]),
        .tx_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .frame_done(done_v[3]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected line levels per tick interval: SYNC(1), start(0), data LSB
    // first, parity (instances 1 and 2), then the stop bits.
    task automatic push(input int d, input logic [7:0] data, input logic par);
        exp_t e;
        int   n;
        e.dut  = d;
        e.bits = '0;
        e.bits[0] = 1'b1;
        e.bits[1] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[2+i] = data[i];
        n = 10;
        if (d == 1 || d == 2) begin
            e.bits[n] = par;
            n++;
        end
        for (int s = 0; s < ((d == 3) ? 2 : 1); s++) begin
            e.bits[n] = 1'b1;
            n++;
        end
        e.len = n;
        sb_q.push_back(e);
    endtask

    // Baud strobe generator
    initial begin
        baud_tick = 1'b0;
        tick_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_mode == 1) begin
                baud_tick = (tick_cnt == 3);
                tick_cnt  = (tick_cnt + 1) % 4;
            end else if (tick_mode == 2) begin
                baud_tick = 1'b1;
            end else begin
                baud_tick = 1'b0;
            end
        end
    end

    // Monitor: one recorded bit per tick while busy; compare on frame_done
    logic [15:0] acc [4];
    int          cnt [4];
    logic [3:0]  rdy_pend;
    exp_t        mon_e;
    initial begin
        rdy_pend = '0;
        for (int d = 0; d < 4; d++) begin
            acc[d] = '0;
            cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (rdy_pend[d] && !rst) chk("ready_after_done", 32'(ready_v[d]), 32'd1);
                rdy_pend[d] = 1'b0;
                if (rst) begin
                    cnt[d] = 0;
                    acc[d] = '0;
                end else begin
                    if (baud_tick && busy_v[d]) begin
                        if (cnt[d] < 16) acc[d][cnt[d]] = tx_v[d];
                        cnt[d]++;
                    end
                    if (done_v[d]) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame_done: dut %0d got frame, expected none", d);
                        end else begin
                            mon_e = sb_q.pop_front();
                            chk("frame_dut", 32'(d), 32'(mon_e.dut));
                            chk("frame_len", 32'(cnt[d]), 32'(mon_e.len));
                            chk("frame_bits", 32'(acc[d]), 32'(mon_e.bits));
                        end
                        frames_seen++;
                        rdy_pend[d] = 1'b1;
                        cnt[d] = 0;
                        acc[d] = '0;
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [7:0] data, input logic par, input bit expect_frame);
        int w;
        @(posedge clk);
        #1;
        tv[d] = 1'b1;
        td[d] = data;
        w = 0;
        @(negedge clk);
        while (!ready_v[d] && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!ready_v[d]) chk("accept_timeout", 32'd0, 32'd1);
        else if (expect_frame) push(d, data, par);
        @(posedge clk);
        #1;
        tv[d] = 1'b0;
        td[d] = ~data;
    endtask

    task automatic wait_frames(input int target);
        int w;
        w = 0;
        while (frames_seen < target && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (frames_seen < target) chk("frame_timeout", 32'(frames_seen), 32'(target));
    endtask

    // Directed stimulus
    initial begin
        int   w, n, accepts, bad;
        logic prev;
        rst = 1'b1;
        tv  = '0;
        for (int d = 0; d < 4; d++) td[d] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("rst_tx", 32'(tx_v[d]), 32'd1);
            chk("rst_busy", 32'(busy_v[d]), 32'd0);
            chk("rst_done", 32'(done_v[d]), 32'd0);
            chk("rst_ready", 32'(ready_v[d]), 32'd0);
        end

        // First accept on the first cycle out of reset; 0xA5 on defaults
        @(posedge clk);
        #1;
        rst   = 1'b0;
        tv[0] = 1'b1;
        td[0] = 8'hA5;
        @(negedge clk);
        chk("first_accept_ready", 32'(ready_v[0]), 32'd1);
        push(0, 8'hA5, 1'b0);
        @(posedge clk);
        #1;
        tv[0] = 1'b0;
        td[0] = 8'h00;
        @(negedge clk);
        chk("busy_after_accept", 32'(busy_v[0]), 32'd1);
        wait_frames(1);

        // Parity: 0x07 has three ones
        send(1, 8'h07, 1'b1, 1'b1);
        wait_frames(2);
        send(2, 8'h07, 1'b0, 1'b1);
        wait_frames(3);

        // Two stop bits, back-to-back with tx_valid held
        @(posedge clk);
        #1;
        tv[3] = 1'b1;
        td[3] = 8'h00;
        @(negedge clk);
        chk("b2b_first_ready", 32'(ready_v[3]), 32'd1);
        push(3, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        td[3] = 8'hFF;
        prev = 1'b0;
        w = 0;
        @(negedge clk);
        while (!ready_v[3] && w < 500) begin
            prev = done_v[3];
            @(negedge clk);
            w++;
        end
        chk("b2b_accept_after_done", 32'(prev), 32'd1);
        push(3, 8'hFF, 1'b0);
        @(posedge clk);
        #1;
        tv[3] = 1'b0;
        wait_frames(5);

        // Accept coincident with a tick: SYNC must last a full interval
        w = 0;
        @(negedge clk);
        while (!baud_tick && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
        tv[0] = 1'b1;
        td[0] = 8'hC3;
        @(negedge clk);
        chk("coincident_tick", 32'(baud_tick), 32'd1);
        chk("coincident_ready", 32'(ready_v[0]), 32'd1);
        push(0, 8'hC3, 1'b0);
        @(posedge clk);
        #1;
        tv[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (tx_v[0] == 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("sync_len", 32'(n), 32'd4);
        wait_frames(6);

        // Tick held high every cycle: 0x96 has four ones, even parity 0
        tick_mode = 2;
        send(1, 8'h96, 1'b0, 1'b1);
        wait_frames(7);
        tick_mode = 1;

        // Reset during data bit 3 of 0xF0 (bit 3 is 0)
        send(0, 8'hF0, 1'b0, 1'b0);
        w = 0;
        while (cnt[0] != 5 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("data_bit3_low", 32'(tx_v[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        chk("midrst_ready", 32'(ready_v[0]), 32'd0);
        chk("midrst_done", 32'(done_v[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_tx", 32'(tx_v[0]), 32'd1);
        chk("postrst_busy", 32'(busy_v[0]), 32'd0);
        repeat (10) @(negedge clk);
        chk("postrst_no_frame", 32'(frames_seen), 32'd7);
        send(0, 8'h3C, 1'b0, 1'b1);
        wait_frames(8);

        // tx_valid held with no ticks for 100 clk
        tick_mode = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tv[0] = 1'b1;
        td[0] = 8'h11;
        accepts = 0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_v[0] && tv[0]) begin
                accepts++;
                if (accepts == 1) push(0, 8'h11, 1'b0);
            end else if (accepts > 0) begin
                if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b1 || ready_v[0] !== 1'b0) bad++;
            end
        end
        chk("stall_accepts", 32'(accepts), 32'd1);
        chk("stall_hold_violations", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        tv[0] = 1'b0;
        tick_mode = 1;
        wait_frames(9);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("frame_count", 32'(frames_seen), 32'd9);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
